// File: rtl/wb_arb_pkg.sv
// Shared types and requester encoding for the PRF write-port-2 arbiter.
package wb_arb_pkg;

   localparam int unsigned PrfIdxW = 6;
   localparam int unsigned DataW   = 32;
   localparam int unsigned RobW    = 6;

   typedef struct packed {
      logic [PrfIdxW-1:0] dest;
      logic [DataW-1:0]   data;
      logic [RobW-1:0]    rob;
   } wb_entry_t;

   localparam logic ReqLq = 1'b0;
   localparam logic ReqMs = 1'b1;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Producer handshakes and PRF/ROB write-back signals of the port-2 arbiter.
interface wb_port_arbiter_if #(
   parameter int unsigned PRF_IDX_W = 6,
   parameter int unsigned ROB_W     = 6
);
   logic                 flush_i;
   logic                 lq_vld_i;
   logic [PRF_IDX_W-1:0] lq_dest_i;
   logic [31:0]          lq_data_i;
   logic [ROB_W-1:0]     lq_rob_i;
   logic                 lq_rdy_o;
   logic                 ms_vld_i;
   logic [PRF_IDX_W-1:0] ms_dest_i;
   logic [31:0]          ms_data_i;
   logic [ROB_W-1:0]     ms_rob_i;
   logic                 ms_rdy_o;
   logic                 p2_we_o;
   logic [PRF_IDX_W-1:0] p2_we_dest_o;
   logic [31:0]          p2_we_data_o;
   logic                 cmp_vld_o;
   logic [ROB_W-1:0]     cmp_rob_o;

   modport slave (
      input  flush_i, lq_vld_i, lq_dest_i, lq_data_i, lq_rob_i,
      input  ms_vld_i, ms_dest_i, ms_data_i, ms_rob_i,
      output lq_rdy_o, ms_rdy_o, p2_we_o, p2_we_dest_o, p2_we_data_o, cmp_vld_o, cmp_rob_o
   );

   modport master (
      output flush_i, lq_vld_i, lq_dest_i, lq_data_i, lq_rob_i,
      output ms_vld_i, ms_dest_i, ms_data_i, ms_rob_i,
      input  lq_rdy_o, ms_rdy_o, p2_we_o, p2_we_dest_o, p2_we_data_o, cmp_vld_o, cmp_rob_o
   );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrap-bit pointers, async reset and synchronous clear.
module wb_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AddrW = $clog2(Depth);

   logic [AddrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push, do_pop;

   assign full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

   // Clear wins over any same-cycle push or pop.
   assign do_push = push_i & ~full_o & ~clear_i;
   assign do_pop  = pop_i & ~empty_o & ~clear_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AddrW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AddrW+1)'(do_pop);
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
   end
endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing PRF write port 2 between the load queue and
// the memory scheduler, with per-producer queues and registered outputs.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned PRF_IDX_W = 6,
   parameter int unsigned ROB_W     = 6
) (
   input logic              cpu_clk_i,
   input logic              cpu_rstn_i,
   wb_port_arbiter_if.slave bus
);
   localparam int unsigned EntryW = PRF_IDX_W + DataW + ROB_W;

   logic [EntryW-1:0]    lq_head, ms_head;
   logic                 lq_full, lq_empty, ms_full, ms_empty;
   logic                 lq_pop, ms_pop;
   logic                 rr_q;
   logic                 we_q;
   logic [PRF_IDX_W-1:0] dest_q;
   logic [DataW-1:0]     data_q;
   logic [ROB_W-1:0]     rob_q;

   assign bus.lq_rdy_o = ~lq_full;
   assign bus.ms_rdy_o = ~ms_full;

   // Pointer only matters when both heads are present.
   assign lq_pop = ~bus.flush_i & ~lq_empty & (ms_empty | (rr_q == ReqLq));
   assign ms_pop = ~bus.flush_i & ~ms_empty & (lq_empty | (rr_q == ReqMs));

   wb_fifo #(.Depth(DEPTH), .Width(EntryW)) u_lq_fifo (
      .clk_i   (cpu_clk_i),
      .rst_ni  (cpu_rstn_i),
      .clear_i (bus.flush_i),
      .push_i  (bus.lq_vld_i),
      .data_i  ({bus.lq_dest_i, bus.lq_data_i, bus.lq_rob_i}),
      .pop_i   (lq_pop),
      .head_o  (lq_head),
      .full_o  (lq_full),
      .empty_o (lq_empty)
   );

   wb_fifo #(.Depth(DEPTH), .Width(EntryW)) u_ms_fifo (
      .clk_i   (cpu_clk_i),
      .rst_ni  (cpu_rstn_i),
      .clear_i (bus.flush_i),
      .push_i  (bus.ms_vld_i),
      .data_i  ({bus.ms_dest_i, bus.ms_data_i, bus.ms_rob_i}),
      .pop_i   (ms_pop),
      .head_o  (ms_head),
      .full_o  (ms_full),
      .empty_o (ms_empty)
   );

   always_ff @(posedge cpu_clk_i or negedge cpu_rstn_i) begin
      if (!cpu_rstn_i) begin
         rr_q   <= ReqLq;
         we_q   <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         rob_q  <= '0;
      end else if (bus.flush_i) begin
         rr_q   <= ReqLq;
         we_q   <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         rob_q  <= '0;
      end else begin
         we_q <= lq_pop | ms_pop;
         if (lq_pop) begin
            {dest_q, data_q, rob_q} <= lq_head;
         end else if (ms_pop) begin
            {dest_q, data_q, rob_q} <= ms_head;
         end
         if (!lq_empty && !ms_empty) rr_q <= ~rr_q;
      end
   end

   assign bus.p2_we_o      = we_q;
   assign bus.p2_we_dest_o = dest_q;
   assign bus.p2_we_data_o = data_q;
   assign bus.cmp_vld_o    = we_q;
   assign bus.cmp_rob_o    = rob_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a queue-based reference model.
module tb_wb_port_arbiter;
   import wb_arb_pkg::*;

   localparam int unsigned Depth = 2;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   wb_port_arbiter_if #(.PRF_IDX_W(6), .ROB_W(6)) bus ();

   wb_port_arbiter #(.DEPTH(Depth), .PRF_IDX_W(6), .ROB_W(6)) dut (
      .cpu_clk_i  (clk),
      .cpu_rstn_i (rstn),
      .bus        (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   wb_entry_t lq_m[$];
   wb_entry_t ms_m[$];
   bit        ptr_ms  = 1'b0;
   bit        exp_we  = 1'b0;
   wb_entry_t exp_out = '0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      lq_m.delete();
      ms_m.delete();
      ptr_ms  = 1'b0;
      exp_we  = 1'b0;
      exp_out = '0;
   endtask

   // One clock edge of the arbiter, computed from the queue rules.
   task automatic model_edge();
      bit        lq_acc, ms_acc, lne, mne, take_lq;
      wb_entry_t e;
      lq_acc = bus.lq_vld_i && (lq_m.size() < Depth);
      ms_acc = bus.ms_vld_i && (ms_m.size() < Depth);
      if (bus.flush_i) begin
         model_reset();
         return;
      end
      lne     = lq_m.size() > 0;
      mne     = ms_m.size() > 0;
      take_lq = lne && (!mne || !ptr_ms);
      if (lne && mne) ptr_ms = !ptr_ms;
      if (take_lq) begin
         exp_out = lq_m.pop_front();
         exp_we  = 1'b1;
      end else if (mne) begin
         exp_out = ms_m.pop_front();
         exp_we  = 1'b1;
      end else begin
         exp_we = 1'b0;
      end
      if (lq_acc) begin
         e.dest = bus.lq_dest_i; e.data = bus.lq_data_i; e.rob = bus.lq_rob_i;
         lq_m.push_back(e);
      end
      if (ms_acc) begin
         e.dest = bus.ms_dest_i; e.data = bus.ms_data_i; e.rob = bus.ms_rob_i;
         ms_m.push_back(e);
      end
   endtask

   task automatic check_outputs();
      check_val("p2_we",   bus.p2_we_o,      exp_we);
      check_val("cmp_vld", bus.cmp_vld_o,    exp_we);
      check_val("dest",    bus.p2_we_dest_o, exp_out.dest);
      check_val("data",    bus.p2_we_data_o, exp_out.data);
      check_val("rob",     bus.cmp_rob_o,    exp_out.rob);
      check_val("lq_rdy",  bus.lq_rdy_o,     lq_m.size() < Depth);
      check_val("ms_rdy",  bus.ms_rdy_o,     ms_m.size() < Depth);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_lq(input bit v, input logic [5:0] d, input logic [31:0] dat,
                         input logic [5:0] r);
      bus.lq_vld_i = v; bus.lq_dest_i = d; bus.lq_data_i = dat; bus.lq_rob_i = r;
   endtask

   task automatic set_ms(input bit v, input logic [5:0] d, input logic [31:0] dat,
                         input logic [5:0] r);
      bus.ms_vld_i = v; bus.ms_dest_i = d; bus.ms_data_i = dat; bus.ms_rob_i = r;
   endtask

   task automatic idle();
      set_lq(1'b0, '0, '0, '0);
      set_ms(1'b0, '0, '0, '0);
      bus.flush_i = 1'b0;
   endtask

   task automatic set_rand_lq();
      set_lq(1'b1, 6'($urandom), $urandom, 6'($urandom));
   endtask

   task automatic set_rand_ms();
      set_ms(1'b1, 6'($urandom), $urandom, 6'($urandom));
   endtask

   initial begin
      bit saw_ms_stall;
      int nwr, we_seen;
      idle();
      #1 rstn = 1'b0;
      #2;
      check_outputs();
      @(negedge clk);
      rstn = 1'b1;

      // Single write, two-edge latency, one-cycle pulse
      set_lq(1'b1, 6'd5, 32'hDEADBEEF, 6'd3);
      step();
      idle();
      step();
      check_val("single_we", bus.p2_we_o, 1'b1);
      check_val("single_dest", bus.p2_we_dest_o, 6'd5);
      check_val("single_data", bus.p2_we_data_o, 32'hDEADBEEF);
      check_val("single_rob", bus.cmp_rob_o, 6'd3);
      step();
      check_val("single_once", bus.p2_we_o, 1'b0);

      // Contention: LQ first, then MS; second pair MS first
      set_lq(1'b1, 6'd1, $urandom, 6'd10);
      set_ms(1'b1, 6'd2, $urandom, 6'd11);
      step();
      idle();
      step();
      check_val("cont1_first", bus.p2_we_dest_o, 6'd1);
      step();
      check_val("cont1_second", bus.p2_we_dest_o, 6'd2);
      set_lq(1'b1, 6'd3, $urandom, 6'd12);
      set_ms(1'b1, 6'd4, $urandom, 6'd13);
      step();
      idle();
      step();
      check_val("cont2_first", bus.p2_we_dest_o, 6'd4);
      step();
      check_val("cont2_second", bus.p2_we_dest_o, 6'd3);
      step();

      // Backpressure: both producers push continuously
      saw_ms_stall = 1'b0;
      for (int i = 0; i < 12; i++) begin
         set_rand_lq();
         set_rand_ms();
         step();
         if (!bus.ms_rdy_o) saw_ms_stall = 1'b1;
      end
      check_val("bp_ms_stall", saw_ms_stall, 1'b1);
      idle();
      for (int i = 0; i < 6; i++) step();

      // Flush with pending entries and a concurrent LQ push
      set_rand_lq();
      set_rand_ms();
      step();
      set_rand_lq();
      step();
      set_rand_lq();
      bus.flush_i = 1'b1;
      step();
      idle();
      we_seen = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         we_seen += int'(bus.p2_we_o);
      end
      check_val("flush_no_we", we_seen, 0);
      check_val("flush_lq_rdy", bus.lq_rdy_o, 1'b1);
      check_val("flush_ms_rdy", bus.ms_rdy_o, 1'b1);
      set_lq(1'b1, 6'd9, 32'h0000_1234, 6'd9);
      step();
      idle();
      step();
      check_val("post_flush_we", bus.p2_we_o, 1'b1);
      check_val("post_flush_data", bus.p2_we_data_o, 32'h0000_1234);

      // Asynchronous reset while a write is on the port
      set_rand_lq();
      set_rand_ms();
      step();
      idle();
      step();
      check_val("areset_pre_we", bus.p2_we_o, 1'b1);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_val("areset_we", bus.p2_we_o, 1'b0);
      check_val("areset_cmp", bus.cmp_vld_o, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      check_outputs();
      set_lq(1'b1, 6'd21, $urandom, 6'd1);
      set_ms(1'b1, 6'd22, $urandom, 6'd2);
      step();
      idle();
      step();
      check_val("areset_tie_lq", bus.p2_we_dest_o, 6'd21);
      step();
      step();

      // Wrap-around: LQ alone streams ten pushes
      nwr = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 10) set_lq(1'b1, 6'($urandom), 32'(i), 6'($urandom));
         else idle();
         step();
         if (bus.p2_we_o) begin
            check_val("wrap_data", bus.p2_we_data_o, 32'(nwr));
            nwr++;
         end
      end
      check_val("wrap_count", nwr, 10);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) set_rand_lq(); else set_lq(1'b0, '0, '0, '0);
         if ($urandom_range(0, 2) != 0) set_rand_ms(); else set_ms(1'b0, '0, '0, '0);
         bus.flush_i = ($urandom_range(0, 31) == 0);
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
